instr_fetch_unit: RTL and testbench

//  Fetch stage ahead of decode and immediate extension.
//  - Owns the PC and issues one-outstanding requests to instruction memory.
//  - Buffers returned instruction words with their PC in a small FIFO.
//  - Presents the FIFO head to decode over a valid/ready handshake.
//  - Redirects from branch/jump resolution flush the buffer and any in-flight fetch.

---
 rtl/instr_fetch_unit_if.sv | 25 ++
 rtl/instr_fetch_unit.sv | 139 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction memory request/response plus the decode handshake.
// master = fetch unit, slave = memory/decode side.
interface instr_fetch_unit_if #(
   parameter int unsigned XLEN = 32
);
   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_gnt;
   logic            imem_rvalid;
   logic [31:0]     imem_rdata;
   logic            instr_valid;
   logic            instr_ready;
   logic [31:0]     instr_data;
   logic [XLEN-1:0] instr_pc;

   modport master (
      output imem_req, imem_addr, instr_valid, instr_data, instr_pc,
      input  imem_gnt, imem_rvalid, imem_rdata, instr_ready
   );

   modport slave (
      input  imem_req, imem_addr, instr_valid, instr_data, instr_pc,
      output imem_gnt, imem_rvalid, imem_rdata, instr_ready
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: one-outstanding imem requests feeding a PC-tagged instruction FIFO.
// Optional FETCH_ALIGN_CHECK_EN: misaligned redirects raise a sticky fault instead of truncating.
//  state | meaning
//  IDLE  | no request; buffer slots all taken, or fetch faulted
//  REQ   | imem_req asserted at pc, waiting for gnt
//  WAIT  | request granted, waiting for rvalid
module instr_fetch_unit #(
   parameter int unsigned     XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_PC  = '0,
   parameter int unsigned     BUF_DEPTH = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   instr_fetch_unit_if.master        bus,
   input  logic                      redirect_valid,
   input  logic [XLEN-1:0]           redirect_pc,
   output logic                      fetch_fault
);
   localparam int unsigned     PTR_W    = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int unsigned     CNT_W    = $clog2(BUF_DEPTH + 1);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUF_DEPTH - 1);
   localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(BUF_DEPTH);

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   state_t           state, state_nxt;
   logic [XLEN-1:0]  pc, req_pc, target_pc;
   logic             discard, fault_q, misaligned;
   logic [CNT_W-1:0] count, count_nxt;
   logic [PTR_W-1:0] rd_ptr, wr_ptr;
   logic [XLEN-1:0]  buf_pc   [BUF_DEPTH];
   logic [31:0]      buf_data [BUF_DEPTH];
   logic             granted, rsp, push, pop, in_flight;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
   endfunction

   assign granted   = (state == REQ) && bus.imem_gnt;
   assign rsp       = (state == WAIT) && bus.imem_rvalid;
   assign pop       = bus.instr_valid && bus.instr_ready;
   assign push      = rsp && !discard && !redirect_valid;
   // A fetch still owed to us after this edge must be swallowed on a redirect.
   assign in_flight = granted || ((state == WAIT) && !bus.imem_rvalid);

`ifdef FETCH_ALIGN_CHECK_EN
   assign misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);
   assign target_pc  = redirect_pc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fault_q <= 1'b0;
      end else if (redirect_valid) begin
         fault_q <= misaligned;
      end
   end
`else
   assign misaligned = 1'b0;
   assign target_pc  = redirect_pc & ~XLEN'(3);
   assign fault_q    = 1'b0;
`endif

   assign fetch_fault     = fault_q;
   assign bus.imem_addr   = pc;
   assign bus.instr_valid = (count != '0);
   assign bus.instr_data  = buf_data[rd_ptr];
   assign bus.instr_pc    = buf_pc[rd_ptr];

   always_comb begin
      count_nxt = count;
      if (redirect_valid) begin
         count_nxt = '0;
      end else if (push && !pop) begin
         count_nxt = count + CNT_W'(1);
      end else if (pop && !push) begin
         count_nxt = count - CNT_W'(1);
      end
   end

   always_comb begin
      state_nxt    = state;
      bus.imem_req = 1'b0;
      case (state)
         IDLE: if (!fault_q && (count < DEPTH_C)) state_nxt = REQ;
         REQ: begin
            bus.imem_req = 1'b1;
            if (bus.imem_gnt) state_nxt = WAIT;
         end
         WAIT: if (bus.imem_rvalid) state_nxt = (count_nxt < DEPTH_C) ? REQ : IDLE;
         default: state_nxt = IDLE;
      endcase
      if (redirect_valid) begin
         if (misaligned) begin
            state_nxt = IDLE;
         end else if (in_flight) begin
            state_nxt = WAIT;
         end else begin
            state_nxt = REQ;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         pc      <= RESET_PC;
         req_pc  <= '0;
         discard <= 1'b0;
         count   <= '0;
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         for (int i = 0; i < int'(BUF_DEPTH); i++) begin
            buf_pc[i]   <= '0;
            buf_data[i] <= '0;
         end
      end else begin
         state <= state_nxt;
         count <= count_nxt;
         if (redirect_valid) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            discard <= in_flight && !misaligned;
            if (!misaligned) pc <= target_pc;
         end else begin
            if (granted) begin
               req_pc <= pc;
               pc     <= pc + XLEN'(4);
            end
            if (rsp) discard <= 1'b0;
            if (push) begin
               buf_pc[wr_ptr]   <= req_pc;
               buf_data[wr_ptr] <= bus.imem_rdata;
               wr_ptr           <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
         end
      end
   end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed tests with an expected-pop queue and a decoupled monitor.
module tb_instr_fetch_unit;
   logic        clk;
   logic        rst_n;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        fetch_fault;
   logic        gnt, rvalid, instr_ready;
   logic [31:0] rdata;

   instr_fetch_unit_if #(.XLEN(32)) bus ();

   assign bus.imem_gnt    = gnt;
   assign bus.imem_rvalid = rvalid;
   assign bus.imem_rdata  = rdata;
   assign bus.instr_ready = instr_ready;

   instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .BUF_DEPTH(2)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .bus            (bus),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .fetch_fault    (fetch_fault)
   );

   int          checks = 0;
   int          errors = 0;
   int          cyc    = 0;
   logic [31:0] exp_pc[$];
   logic [31:0] exp_data[$];
   int          pop_cyc[$];

   // memory model controls
   int          budget   = 0;
   int          lat      = 1;
   bit          pend     = 0;
   int          pend_cnt = 0;
   logic [31:0] pend_addr = '0;
   bit          stray    = 0;

   logic [31:0] mon_pc, mon_data;

   function automatic logic [31:0] word(input logic [31:0] a);
      return 32'h1300_0013 ^ {a[15:0], a[31:16]} ^ a;
   endfunction

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // instruction memory: grants while budget lasts, answers lat cycles later
   initial begin
      gnt = 1'b0; rvalid = 1'b0; rdata = '0;
      forever begin
         @(negedge clk);
         rvalid = 1'b0;
         gnt    = 1'b0;
         if (stray) begin
            rvalid = 1'b1;
            rdata  = 32'hDEAD_BEEF;
            stray  = 0;
         end else if (pend) begin
            if (pend_cnt == 0) begin
               rvalid = 1'b1;
               rdata  = word(pend_addr);
               pend   = 0;
            end else begin
               pend_cnt--;
            end
         end
         if (bus.imem_req && budget > 0 && !pend) begin
            gnt       = 1'b1;
            pend      = 1;
            pend_addr = bus.imem_addr;
            pend_cnt  = lat - 1;
            budget--;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && bus.instr_valid && instr_ready) begin
            pop_cyc.push_back(cyc);
            checks++;
            if (exp_pc.size() == 0) begin
               errors++;
               $display("FAIL unexpected_pop got pc=%h data=%h, required no pop", bus.instr_pc, bus.instr_data);
            end else begin
               mon_pc   = exp_pc.pop_front();
               mon_data = exp_data.pop_front();
               if (bus.instr_pc !== mon_pc || bus.instr_data !== mon_data) begin
                  errors++;
                  $display("FAIL pop got pc=%h data=%h, required pc=%h data=%h",
                           bus.instr_pc, bus.instr_data, mon_pc, mon_data);
               end
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s got %h, required %h", name, act, req);
      end
   endtask

   task automatic expect_fetch(input logic [31:0] a);
      exp_pc.push_back(a);
      exp_data.push_back(word(a));
   endtask

   task automatic do_reset();
      rst_n          = 1'b0;
      budget         = 0;
      pend           = 0;
      stray          = 0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      exp_pc.delete();
      exp_data.delete();
      @(negedge clk);
      check("rst_imem_req",    32'(bus.imem_req),    32'd0);
      check("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
      check("rst_fetch_fault", 32'(fetch_fault),     32'd0);
      check("rst_instr_data",  bus.instr_data,       32'd0);
      check("rst_instr_pc",    bus.instr_pc,         32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic wait_drain(input string name);
      bit done = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         if (exp_pc.size() == 0) begin
            done = 1;
            break;
         end
      end
      #1;
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL %s_drain got %0d pending pops, required 0", name, exp_pc.size());
         exp_pc.delete();
         exp_data.delete();
      end
   endtask

   task automatic wait_gnt(input string name);
      bit seen = 0;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk);
         if (gnt) begin
            seen = 1;
            break;
         end
      end
      #1;
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL %s_gnt got no grant, required one", name);
      end
   endtask

   task automatic redirect(input logic [31:0] target);
      redirect_valid = 1'b1;
      redirect_pc    = target;
      @(posedge clk); #1;
      redirect_valid = 1'b0;
   endtask

   initial begin
      rst_n          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      instr_ready    = 1'b0;

      // T1 sequential fetch at full rate
      do_reset();
      instr_ready = 1'b1; lat = 1; budget = 3;
      pop_cyc.delete();
      expect_fetch(32'h0); expect_fetch(32'h4); expect_fetch(32'h8);
      wait_drain("t1");
      check("t1_pops", 32'(pop_cyc.size()), 32'd3);
      if (pop_cyc.size() >= 3) begin
         check("t1_gap01", 32'(pop_cyc[1] - pop_cyc[0]), 32'd2);
         check("t1_gap12", 32'(pop_cyc[2] - pop_cyc[1]), 32'd2);
      end

      // T2 backpressure fills the buffer then stops requesting
      do_reset();
      instr_ready = 1'b0; lat = 1; budget = 3;
      expect_fetch(32'h0); expect_fetch(32'h4); expect_fetch(32'h8);
      repeat (12) @(posedge clk);
      @(negedge clk);
      check("t2_req_stopped", 32'(bus.imem_req),    32'd0);
      check("t2_head_valid",  32'(bus.instr_valid), 32'd1);
      check("t2_head_pc",     bus.instr_pc,         32'h0);
      check("t2_grants",      32'(budget),          32'd1);
      @(posedge clk); #1;
      instr_ready = 1'b1;
      wait_drain("t2");

      // T3 redirect while a fetch is outstanding
      do_reset();
      instr_ready = 1'b1; lat = 1; budget = 1;
      expect_fetch(32'h0);
      wait_drain("t3a");
      lat = 2; budget = 1;
      wait_gnt("t3");
      budget = 2;
      expect_fetch(32'h100); expect_fetch(32'h104);
      redirect(32'h100);
      lat = 1;
      @(negedge clk);
      check("t3_valid_after_redirect", 32'(bus.instr_valid), 32'd0);
      check("t3_req_held_for_discard", 32'(bus.imem_req),    32'd0);
      wait_drain("t3");

      // T4 PC wrap
      do_reset();
      instr_ready = 1'b1; lat = 1;
      repeat (3) @(posedge clk); #1;
      redirect(32'hFFFF_FFFC);
      budget = 2;
      expect_fetch(32'hFFFF_FFFC); expect_fetch(32'h0000_0000);
      wait_drain("t4");

      // T5 misaligned redirect
      do_reset();
      instr_ready = 1'b1; lat = 1;
      repeat (3) @(posedge clk); #1;
      redirect(32'h102);
`ifdef FETCH_ALIGN_CHECK_EN
      budget = 1;
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("t5_fault_set",  32'(fetch_fault),  32'd1);
      check("t5_req_quiet",  32'(bus.imem_req), 32'd0);
      check("t5_no_grant",   32'(budget),       32'd1);
      @(posedge clk); #1;
      expect_fetch(32'h200);
      redirect(32'h200);
      wait_drain("t5");
      check("t5_fault_clear", 32'(fetch_fault), 32'd0);
`else
      budget = 1;
      expect_fetch(32'h100);
      wait_drain("t5");
      check("t5_fault_tied", 32'(fetch_fault), 32'd0);
`endif

      // T6 reset during WAIT, stray rvalid afterwards
      do_reset();
      instr_ready = 1'b1; lat = 1; budget = 1;
      wait_gnt("t6");
      do_reset();
      stray = 1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("t6_no_push", 32'(bus.instr_valid), 32'd0);
      @(posedge clk); #1;
      budget = 1;
      expect_fetch(32'h0);
      wait_drain("t6");

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got timeout, required completion");
      $fatal(1);
   end
endmodule
